// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: a WIDTH-bit add split into STAGES ripple
// chunks of CHUNK bits, one chunk per register stage, with skewed operand
// and sum registers so each transaction exits with all bits aligned.
// A single global advance signal stalls or moves the whole pipeline.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_chunk_check
    $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  // One CHUNK-bit ripple slice; the top bit of the result is the carry out.
  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  // Signed overflow: the carry into the MSB is recovered from the MSB
  // operand and sum bits, then compared with the carry out of the MSB.
  function automatic logic signed_ovf(input logic x_msb, input logic y_msb,
                                      input logic s_msb, input logic co);
    return (x_msb ^ y_msb ^ s_msb) ^ co;
  endfunction

  // Stage registers: valid, remaining operands (b already conditioned for
  // subtraction), partial sum and the carry handed to the next chunk.
  logic             vld_p [STAGES];
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] s_p   [STAGES];
  logic             c_p   [STAGES];
  logic             ovf_p;

  // Per-stage inputs (the predecessor's registers, or the ports for stage 0)
  // and the values each stage will capture on an advancing edge.
  logic             vld_src [STAGES];
  logic [WIDTH-1:0] a_src   [STAGES];
  logic [WIDTH-1:0] b_src   [STAGES];
  logic [WIDTH-1:0] s_src   [STAGES];
  logic             c_src   [STAGES];
  logic [CHUNK:0]   add_k   [STAGES];
  logic [WIDTH-1:0] s_nxt   [STAGES];
  logic             c_nxt   [STAGES];
  logic             ovf_nxt;

  logic adv;

  // The whole pipeline moves together whenever the output slot is free.
  assign adv       = !vld_p[LAST] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p[LAST];
  assign sum       = s_p[LAST];
  assign cout      = c_p[LAST];
  assign ovf       = ovf_p;

  // Route stage sources and compute each stage's chunk of the sum.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      vld_src[k] = 1'b0;
      a_src[k]   = '0;
      b_src[k]   = '0;
      s_src[k]   = '0;
      c_src[k]   = 1'b0;
    end

    // Subtraction is a + ~b + 1; cin is ignored in that mode.
    vld_src[0] = in_valid;
    a_src[0]   = a;
    b_src[0]   = sub ? ~b : b;
    s_src[0]   = '0;
    c_src[0]   = sub ? 1'b1 : cin;

    for (int k = 1; k < STAGES; k++) begin
      vld_src[k] = vld_p[k-1];
      a_src[k]   = a_p[k-1];
      b_src[k]   = b_p[k-1];
      s_src[k]   = s_p[k-1];
      c_src[k]   = c_p[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      add_k[k] = chunk_add(a_src[k][k*CHUNK +: CHUNK],
                           b_src[k][k*CHUNK +: CHUNK], c_src[k]);
      s_nxt[k] = s_src[k];
      s_nxt[k][k*CHUNK +: CHUNK] = add_k[k][CHUNK-1:0];
      c_nxt[k] = add_k[k][CHUNK];
    end

    ovf_nxt = signed_ovf(a_src[LAST][WIDTH-1], b_src[LAST][WIDTH-1],
                         s_nxt[LAST][WIDTH-1], c_nxt[LAST]);
  end

  // Stage valid bits: cleared by reset, shifted on every advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= vld_src[k];
    end
  end

  // Stage data: only the visible output registers are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_p[LAST] <= '0;
      c_p[LAST] <= 1'b0;
      ovf_p     <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_p[k] <= a_src[k];
        b_p[k] <= b_src[k];
        s_p[k] <= s_nxt[k];
        c_p[k] <= c_nxt[k];
      end
      ovf_p <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three instances (CHUNK 4, 16, 1) each with a
// queue scoreboard fed at acceptance and drained by a negedge monitor, plus
// directed value, latency, backpressure and reset scenarios on CHUNK=4.
module tb_pipelined_addsub;

  localparam int W    = 16;
  localparam int NDUT = 3;
  localparam int LAT0 = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid_v  [NDUT];
  logic         in_ready_v  [NDUT];
  logic [W-1:0] a_v         [NDUT];
  logic [W-1:0] b_v         [NDUT];
  logic         cin_v       [NDUT];
  logic         sub_v       [NDUT];
  logic         out_valid_v [NDUT];
  logic         out_ready_v [NDUT];
  logic [W-1:0] sum_v       [NDUT];
  logic         cout_v      [NDUT];
  logic         ovf_v       [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   pops       [NDUT];
  logic stall_prev [NDUT];
  exp_t held       [NDUT];

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .CHUNK(4)) u_dut_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .sub(sub_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));

  pipelined_addsub #(.WIDTH(W), .CHUNK(16)) u_dut_c16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .sub(sub_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));

  pipelined_addsub #(.WIDTH(W), .CHUNK(1)) u_dut_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .sub(sub_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

  // Reference: integer arithmetic on the signed and unsigned interpretations.
  function automatic exp_t ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic ci, input logic sb);
    exp_t e;
    int   sx, sy, r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      r   = sx - sy;
      e.c = (x >= y);
    end else begin
      r   = sx + sy + int'(ci);
      e.c = (int'(x) + int'(y) + int'(ci)) > 65535;
    end
    e.o = (r > 32767) || (r < -32768);
    e.s = r[W-1:0];
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int d, output exp_t e, output bit ok);
    ok = 1'b1;
    e  = '0;
    case (d)
      0:       if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
      1:       if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Monitor: everything sampled at negedge reflects what the next rising
  // edge will see, so transfers are recognised exactly once.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      exp_t e;
      bit   ok;
      if (rst) begin
        case (d)
          0:       q0.delete();
          1:       q1.delete();
          default: q2.delete();
        endcase
        stall_prev[d] = 1'b0;
      end else begin
        chk($sformatf("in_ready_rule_d%0d", d), {31'b0, in_ready_v[d]},
            {31'b0, !out_valid_v[d] || out_ready_v[d]});
        if (stall_prev[d]) begin
          chk($sformatf("stall_hold_d%0d", d),
              {13'b0, out_valid_v[d], sum_v[d], cout_v[d], ovf_v[d]},
              {13'b0, 1'b1, held[d].s, held[d].c, held[d].o});
        end
        if (in_valid_v[d] && in_ready_v[d])
          push_exp(d, ref_model(a_v[d], b_v[d], cin_v[d], sub_v[d]));
        if (out_valid_v[d] && out_ready_v[d]) begin
          pop_exp(d, e, ok);
          chk($sformatf("unexpected_out_d%0d", d), {31'b0, ok}, 32'd1);
          if (ok)
            chk($sformatf("result_d%0d", d), {14'b0, sum_v[d], cout_v[d], ovf_v[d]},
                {14'b0, e.s, e.c, e.o});
          pops[d]++;
        end
        stall_prev[d] = out_valid_v[d] && !out_ready_v[d];
        held[d]       = '{s: sum_v[d], c: cout_v[d], o: ovf_v[d]};
      end
    end
  end

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic idle_all();
    for (int d = 0; d < NDUT; d++) begin
      in_valid_v[d]  = 1'b0;
      out_ready_v[d] = 1'b1;
      a_v[d]   = '0;
      b_v[d]   = '0;
      cin_v[d] = 1'b0;
      sub_v[d] = 1'b0;
    end
  endtask

  // Issue one op to the CHUNK=4 instance on an empty pipeline and check
  // latency and result against fixed expected values.
  task automatic directed_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic ci, input logic sb, input logic [W-1:0] es,
                             input logic ec, input logic eo);
    int n;
    in_valid_v[0] = 1'b1;
    a_v[0] = x; b_v[0] = y; cin_v[0] = ci; sub_v[0] = sb;
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    n = 1;
    while (!out_valid_v[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, n, LAT0);
    chk({name, "_sum"},  {16'b0, sum_v[0]}, {16'b0, es});
    chk({name, "_cout"}, {31'b0, cout_v[0]}, {31'b0, ec});
    chk({name, "_ovf"},  {31'b0, ovf_v[0]}, {31'b0, eo});
    @(posedge clk); #1;
  endtask

  logic [W-1:0] bp_a [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'hABCD};
  logic [W-1:0] bp_b [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h8000, 16'h1111};
  logic         bp_s [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int base, i, n;
    logic [W-1:0] s5;
    for (int d = 0; d < NDUT; d++) begin
      pops[d] = 0;
      stall_prev[d] = 1'b0;
      held[d] = '0;
    end
    idle_all();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and first cycle after reset
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst_out_valid_d%0d", d), {31'b0, out_valid_v[d]}, 32'd0);
      chk($sformatf("rst_outs_d%0d", d), {14'b0, sum_v[d], cout_v[d], ovf_v[d]}, 32'd0);
      chk($sformatf("rst_in_ready_d%0d", d), {31'b0, in_ready_v[d]}, 32'd1);
    end

    // Directed values
    directed_op("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed_op("posovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed_op("sub_cin",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed_op("add_cin",  16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    directed_op("sub_neg",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure: six back-to-back ops, consumer stalls in cycles 5-7
    base = pops[0];
    i = 0;
    s5 = '0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      out_ready_v[0] = !(cyc >= 5 && cyc <= 7);
      if (i < 6) begin
        in_valid_v[0] = 1'b1;
        a_v[0] = bp_a[i]; b_v[0] = bp_b[i]; sub_v[0] = bp_s[i]; cin_v[0] = 1'b0;
      end else begin
        in_valid_v[0] = 1'b0;
      end
      @(negedge clk);
      if (cyc >= 5 && cyc <= 7) begin
        chk("bp_in_ready_stall", {31'b0, in_ready_v[0]}, 32'd0);
        chk("bp_out_valid_stall", {31'b0, out_valid_v[0]}, 32'd1);
        if (cyc == 5) s5 = sum_v[0];
        else chk("bp_sum_frozen", {16'b0, sum_v[0]}, {16'b0, s5});
      end
      if (in_valid_v[0] && in_ready_v[0]) i++;
      @(posedge clk); #1;
    end
    chk("bp_delivered", pops[0] - base, 6);
    chk("bp_queue_empty", qsize(0), 0);

    // Reset mid-flight: three ops accepted, then a one-cycle reset
    out_ready_v[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid_v[0] = 1'b1;
      a_v[0] = 16'h0100 + W'(k); b_v[0] = 16'h0010; sub_v[0] = 1'b0;
      @(posedge clk); #1;
    end
    in_valid_v[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", {31'b0, in_ready_v[0]}, 32'd1);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid_v[0]) n++;
      @(posedge clk); #1;
    end
    chk("midrst_no_ghost", n, 0);
    directed_op("after_rst", 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0);

    // Random regression on all three instances
    for (int cyc = 0; cyc < 15000; cyc++) begin
      for (int d = 0; d < NDUT; d++) begin
        in_valid_v[d]  = ($urandom_range(3) != 0);
        out_ready_v[d] = ($urandom_range(3) != 0);
        a_v[d]   = rand_operand();
        b_v[d]   = rand_operand();
        cin_v[d] = 1'($urandom);
        sub_v[d] = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    idle_all();
    repeat (LAT0 + 16 + 4) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("drain_empty_d%0d", d), qsize(d), 0);
      chk($sformatf("drain_idle_d%0d", d), {31'b0, out_valid_v[d]}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 Parameter WIDTH, default 16, is the operand and result width in bits.
REQ-002 Parameter CHUNK, default 4, is the bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK; STAGES = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b  input  WIDTH each  operands, two's complement or unsigned.
REQ-008 cin  input  1  carry-in, used only when sub=0.
REQ-009 sub  input  1  0 = a+b+cin, 1 = a-b.
REQ-010 out_valid  output  1  result presented.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of bit WIDTH-1; when sub=1, 1 = no borrow.
REQ-014 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 Operation: sub=0 computes a + b + cin; sub=1 computes a + ~b + 1, ignoring cin.
REQ-016 Stage k (k = 0..STAGES-1) adds bits [k*CHUNK +: CHUNK] using the registered carry from stage k-1; stage 0 uses the effective carry-in.
REQ-017 Not-yet-added operand chunks and already-computed sum chunks are carried forward in skew registers, so the final stage presents all WIDTH bits from one transaction.
REQ-018 Each stage holds a valid bit; out_valid is the valid bit of the last stage.
REQ-019 Global advance: adv = !out_valid | out_ready; when adv=1 every stage loads from its predecessor; when adv=0 every stage holds.
REQ-020 in_ready = adv, combinationally; a transfer occurs only when in_valid & in_ready.
REQ-021 When in_valid=0 and adv=1, stage 0 loads a bubble with its valid bit cleared; bubbles are not collapsed.
REQ-022 Latency is exactly STAGES cycles from the accepting edge to out_valid=1 when there is no stall; throughput is one result per cycle.
REQ-023 While out_valid=1 and out_ready=0, sum, cout and ovf SHALL remain stable and no input is accepted.
REQ-024 Results leave the block in acceptance order; no transaction is lost or duplicated under any stall pattern.
REQ-025 CHUNK = WIDTH (STAGES = 1) is legal and gives latency 1.
REQ-026 Wrap-around: sum is the result modulo 2^WIDTH; the carry is reported only on cout.

Reset
REQ-027 While rst=1, all stage valid bits, out_valid, sum, cout and ovf SHALL be 0 on the next edge.
REQ-028 rst asserted mid-operation discards all in-flight transactions; none appears after rst deasserts.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts, because the pipeline is empty.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-030 a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
REQ-031 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1. Also a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0, confirming cin is ignored.
REQ-032 Backpressure: feed 6 back-to-back ops with out_ready=0 for cycles 5-7 -> in_ready=0 during the stall, outputs frozen, all 6 results delivered in order with correct values.
REQ-033 Reset mid-flight: accept 3 ops, assert rst for 1 cycle -> out_valid stays 0 until new input; the next op's result arrives after exactly 4 cycles.
REQ-034 Random regression: 10k random a, b, cin, sub with random in_valid/out_ready -> every result matches a reference model of sum, cout and ovf; repeat with CHUNK=16 and CHUNK=1.
